// File: rtl/beat_detector_multi.sv
// Multi-axis beat detector: moving-average deviation graded against three thresholds.
// Optional `BEAT_AXIS_ID_EN adds beat_axis, the index of the axis that produced the beat.
module beat_detector_multi #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned NUM_AXES = 3,
   parameter int unsigned WIN_LOG2 = 7,
   parameter int unsigned HOLDOFF  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         in_valid,
   input  logic [NUM_AXES*DATA_W-1:0]   samples,
   input  logic [DATA_W-1:0]            thr1,
   input  logic [DATA_W-1:0]            thr2,
   input  logic [DATA_W-1:0]            thr3,
   output logic                         win_ready,
   output logic [NUM_AXES*DATA_W-1:0]   avg,
   output logic                         beat_en,
   output logic [1:0]                   beat_intensity
`ifdef BEAT_AXIS_ID_EN
   ,
   output logic [1:0]                   beat_axis
`endif
);

   localparam int unsigned DEPTH = 1 << WIN_LOG2;
   localparam int unsigned SUM_W = DATA_W + WIN_LOG2;
   localparam int unsigned DEV_W = DATA_W + 1;
   localparam int unsigned HC_W  = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

   typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_HOLD} state_t;

   state_t                     r_state, w_state_nxt;
   logic signed [DATA_W-1:0]   r_buf [NUM_AXES][DEPTH];
   logic [WIN_LOG2-1:0]        r_wptr;
   logic [WIN_LOG2-1:0]        r_fill_cnt, w_fill_nxt;
   logic [HC_W-1:0]            r_hold_cnt, w_hold_nxt;
   logic signed [SUM_W-1:0]    r_sum [NUM_AXES];
   logic signed [SUM_W-1:0]    w_sum_nxt [NUM_AXES];
   logic signed [DATA_W-1:0]   w_new [NUM_AXES];
   logic signed [DATA_W-1:0]   w_old [NUM_AXES];
   logic signed [SUM_W:0]      w_diff [NUM_AXES];
   logic [DEV_W-1:0]           w_dev [NUM_AXES];
   logic [DEV_W-1:0]           w_dmax;
   logic                       r_s1_valid;
   logic [DEV_W-1:0]           r_s1_dmax;
   logic [1:0]                 w_lvl;
   logic                       w_fire;
   logic                       r_beat_en;
   logic [1:0]                 r_intensity;
`ifdef BEAT_AXIS_ID_EN
   logic [1:0]                 w_dmax_axis;
   logic [1:0]                 r_s1_axis;
   logic [1:0]                 r_axis;
`endif

   // Stage 0: window update terms and per-axis deviation against the pre-update average
   always_comb begin
      w_dmax = '0;
`ifdef BEAT_AXIS_ID_EN
      w_dmax_axis = '0;
`endif
      avg = '0;
      for (int unsigned a = 0; a < NUM_AXES; a++) begin
         w_new[a]     = samples[a*DATA_W +: DATA_W];
         w_old[a]     = (r_state == ST_FILL) ? '0 : r_buf[a][r_wptr];
         w_sum_nxt[a] = r_sum[a]
                        - {{WIN_LOG2{w_old[a][DATA_W-1]}}, w_old[a]}
                        + {{WIN_LOG2{w_new[a][DATA_W-1]}}, w_new[a]};
         w_diff[a]    = {{(WIN_LOG2+1){w_new[a][DATA_W-1]}}, w_new[a]}
                        - {r_sum[a][SUM_W-1], (r_sum[a] >>> WIN_LOG2)};
         w_dev[a]     = w_diff[a][SUM_W] ? DEV_W'(-w_diff[a]) : DEV_W'(w_diff[a]);
         if (w_dev[a] > w_dmax) begin
            w_dmax = w_dev[a];
`ifdef BEAT_AXIS_ID_EN
            w_dmax_axis = 2'(a);
`endif
         end
         avg[a*DATA_W +: DATA_W] = DATA_W'(r_sum[a] >>> WIN_LOG2);
      end
   end

   // Later checks override earlier ones so the highest exceeded index wins
   always_comb begin
      w_lvl = 2'd0;
      if (r_s1_dmax > {1'b0, thr1}) w_lvl = 2'd1;
      if (r_s1_dmax > {1'b0, thr2}) w_lvl = 2'd2;
      if (r_s1_dmax > {1'b0, thr3}) w_lvl = 2'd3;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fill_nxt  = r_fill_cnt;
      w_hold_nxt  = r_hold_cnt;
      w_fire      = 1'b0;
      case (r_state)
         ST_FILL: begin
            if (in_valid) begin
               w_fill_nxt = r_fill_cnt + 1'b1;
               if (r_fill_cnt == '1) w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (r_s1_valid && (w_lvl != 2'd0)) begin
               w_fire = 1'b1;
               if (HOLDOFF > 0) begin
                  w_hold_nxt  = HC_W'(HOLDOFF);
                  w_state_nxt = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (in_valid) begin
               w_hold_nxt = r_hold_cnt - 1'b1;
               if (r_hold_cnt == HC_W'(1)) w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_FILL;
      end else if (clr) begin
         r_state <= ST_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr      <= '0;
         r_fill_cnt  <= '0;
         r_hold_cnt  <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_dmax   <= '0;
         r_beat_en   <= 1'b0;
         r_intensity <= 2'd0;
         for (int unsigned a = 0; a < NUM_AXES; a++) r_sum[a] <= '0;
`ifdef BEAT_AXIS_ID_EN
         r_s1_axis   <= 2'd0;
         r_axis      <= 2'd0;
`endif
      end else if (clr) begin
         r_wptr      <= '0;
         r_fill_cnt  <= '0;
         r_hold_cnt  <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_dmax   <= '0;
         r_beat_en   <= 1'b0;
         r_intensity <= 2'd0;
         for (int unsigned a = 0; a < NUM_AXES; a++) r_sum[a] <= '0;
`ifdef BEAT_AXIS_ID_EN
         r_s1_axis   <= 2'd0;
         r_axis      <= 2'd0;
`endif
      end else begin
         r_fill_cnt <= w_fill_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_s1_valid <= in_valid && (r_state != ST_FILL);
         r_s1_dmax  <= w_dmax;
         r_beat_en  <= w_fire;
`ifdef BEAT_AXIS_ID_EN
         r_s1_axis  <= w_dmax_axis;
`endif
         if (w_fire) begin
            r_intensity <= w_lvl;
`ifdef BEAT_AXIS_ID_EN
            r_axis      <= r_s1_axis;
`endif
         end
         if (in_valid) begin
            r_wptr <= r_wptr + 1'b1;
            for (int unsigned a = 0; a < NUM_AXES; a++) r_sum[a] <= w_sum_nxt[a];
         end
      end
   end

   // Window contents are never reset; FILL treats the outgoing entry as zero instead
   always_ff @(posedge clk) begin
      if (in_valid && !clr) begin
         for (int unsigned a = 0; a < NUM_AXES; a++) r_buf[a][r_wptr] <= w_new[a];
      end
   end

   assign win_ready      = (r_state != ST_FILL);
   assign beat_en        = r_beat_en;
   assign beat_intensity = r_intensity;
`ifdef BEAT_AXIS_ID_EN
   assign beat_axis      = r_axis;
`endif

endmodule

// File: tb/tb_beat_detector_multi.sv
// Directed self-checking bench for beat_detector_multi (3 axes, window 8, hold-off 4).
module tb_beat_detector_multi;

   localparam int unsigned DW = 16;
   localparam int unsigned NA = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              clr;
   logic              in_valid;
   logic [NA*DW-1:0]  samples;
   logic [DW-1:0]     thr1, thr2, thr3;
   logic              win_ready;
   logic [NA*DW-1:0]  avg;
   logic              beat_en;
   logic [1:0]        beat_intensity;
`ifdef BEAT_AXIS_ID_EN
   logic [1:0]        beat_axis;
`endif

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   always #5 clk = ~clk;

   beat_detector_multi #(
      .DATA_W   (16),
      .NUM_AXES (3),
      .WIN_LOG2 (3),
      .HOLDOFF  (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .clr            (clr),
      .in_valid       (in_valid),
      .samples        (samples),
      .thr1           (thr1),
      .thr2           (thr2),
      .thr3           (thr3),
      .win_ready      (win_ready),
      .avg            (avg),
      .beat_en        (beat_en),
      .beat_intensity (beat_intensity)
`ifdef BEAT_AXIS_ID_EN
      ,
      .beat_axis      (beat_axis)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; the call returns one falling edge later
   task automatic tick(input logic v, input int x, input int y, input int z);
      in_valid = v;
      samples  = {16'(z), 16'(y), 16'(x)};
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic refill();
      clr = 1'b1;
      tick(1'b0, 1000, 1000, 1000);
      clr = 1'b0;
      for (int i = 0; i < 8; i++) tick(1'b1, 1000, 1000, 1000);
   endtask

   initial begin
      rst = 1'b0; clr = 1'b0; in_valid = 1'b0; samples = '0;
      thr1 = 16'd100; thr2 = 16'd200; thr3 = 16'd300;

      // 1: reset state, fill with one large sample, no beats during FILL
      @(negedge clk);
      @(negedge clk);
      check("rst_beat_en", {31'd0, beat_en}, 32'd0);
      check("rst_intensity", {30'd0, beat_intensity}, 32'd0);
      check("rst_win_ready", {31'd0, win_ready}, 32'd0);
      check("rst_avg", {16'd0, avg[47:32] | avg[31:16] | avg[15:0]}, 32'd0);
      rst = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick(1'b1, (i == 5) ? 5000 : 1000, 1000, 1000);
         check("fill_beat_en", {31'd0, beat_en}, 32'd0);
         check("fill_win_ready", {31'd0, win_ready}, (i == 8) ? 32'd1 : 32'd0);
      end
      tick(1'b0, 0, 0, 0);
      check("fill_tail_beat_en", {31'd0, beat_en}, 32'd0);
      check("fill_avg_x", {16'd0, avg[15:0]}, 32'd1500);
      check("fill_avg_y", {16'd0, avg[31:16]}, 32'd1000);

      // 2: x=1250 against avg 1000 -> dev 250 -> level 2, two clocks later
      refill();
      check("s2_avg_x", {16'd0, avg[15:0]}, 32'd1000);
      tick(1'b1, 1250, 1000, 1000);
      check("s2_t1_beat_en", {31'd0, beat_en}, 32'd0);
      tick(1'b0, 1000, 1000, 1000);
      check("s2_t2_beat_en", {31'd0, beat_en}, 32'd1);
      check("s2_intensity", {30'd0, beat_intensity}, 32'd2);
      tick(1'b0, 1000, 1000, 1000);
      check("s2_t3_beat_en", {31'd0, beat_en}, 32'd0);
      check("s2_intensity_held", {30'd0, beat_intensity}, 32'd2);

      // 3: z=650 -> dev 350 on axis 2 -> level 3
      refill();
      check("s3_clr_intensity", {30'd0, beat_intensity}, 32'd0);
      tick(1'b1, 1000, 1000, 650);
      tick(1'b0, 1000, 1000, 1000);
      check("s3_beat_en", {31'd0, beat_en}, 32'd1);
      check("s3_intensity", {30'd0, beat_intensity}, 32'd3);
`ifdef BEAT_AXIS_ID_EN
      check("s3_beat_axis", {30'd0, beat_axis}, 32'd2);
`endif

      // 4: back-to-back spikes, second suppressed; after 4 samples x=1400 vs avg 1100 -> level 2
      refill();
      tick(1'b1, 1400, 1000, 1000);
      tick(1'b1, 1400, 1000, 1000);
      check("s4_first_beat_en", {31'd0, beat_en}, 32'd1);
      check("s4_first_intensity", {30'd0, beat_intensity}, 32'd3);
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1000, 1000, 1000);
         check("s4_hold_beat_en", {31'd0, beat_en}, 32'd0);
      end
      check("s4_hold_intensity", {30'd0, beat_intensity}, 32'd3);
      check("s4_avg_x", {16'd0, avg[15:0]}, 32'd1100);
      tick(1'b1, 1400, 1000, 1000);
      check("s4_again_t1_beat_en", {31'd0, beat_en}, 32'd0);
      tick(1'b0, 1000, 1000, 1000);
      check("s4_again_beat_en", {31'd0, beat_en}, 32'd1);
      check("s4_again_intensity", {30'd0, beat_intensity}, 32'd2);

      // 5: reset while a spike is in flight, then a full refill is needed
      refill();
      tick(1'b1, 5000, 1000, 1000);
      rst = 1'b0;
      #1;
      check("s5_async_avg_x", {16'd0, avg[15:0]}, 32'd0);
      check("s5_async_win_ready", {31'd0, win_ready}, 32'd0);
      @(negedge clk);
      check("s5_rst_beat_en", {31'd0, beat_en}, 32'd0);
      check("s5_rst_intensity", {30'd0, beat_intensity}, 32'd0);
      rst = 1'b1;
      tick(1'b0, 1000, 1000, 1000);
      check("s5_post_beat_en", {31'd0, beat_en}, 32'd0);
      tick(1'b1, 5000, 1000, 1000);
      tick(1'b0, 1000, 1000, 1000);
      check("s5_fill_spike_beat_en", {31'd0, beat_en}, 32'd0);
      for (int i = 2; i <= 8; i++) begin
         tick(1'b1, 1000, 1000, 1000);
         check("s5_fill_beat_en", {31'd0, beat_en}, 32'd0);
         check("s5_fill_win_ready", {31'd0, win_ready}, (i == 8) ? 32'd1 : 32'd0);
      end
      check("s5_avg_x", {16'd0, avg[15:0]}, 32'd1500);
      tick(1'b1, 1000, 1000, 1000);
      tick(1'b0, 1000, 1000, 1000);
      check("s5_refilled_beat_en", {31'd0, beat_en}, 32'd1);
      check("s5_refilled_intensity", {30'd0, beat_intensity}, 32'd3);

      // 6: clr wins over a simultaneous valid spike; the sample is not counted
      refill();
      clr = 1'b1;
      tick(1'b1, 5000, 1000, 1000);
      clr = 1'b0;
      check("s6_win_ready", {31'd0, win_ready}, 32'd0);
      check("s6_avg_x", {16'd0, avg[15:0]}, 32'd0);
      check("s6_t1_beat_en", {31'd0, beat_en}, 32'd0);
      tick(1'b0, 1000, 1000, 1000);
      check("s6_t2_beat_en", {31'd0, beat_en}, 32'd0);
      tick(1'b0, 1000, 1000, 1000);
      check("s6_t3_beat_en", {31'd0, beat_en}, 32'd0);
      for (int i = 1; i <= 8; i++) begin
         tick(1'b1, 1000, 1000, 1000);
         check("s6_fill_win_ready", {31'd0, win_ready}, (i == 8) ? 32'd1 : 32'd0);
      end
      check("s6_fill_avg_x", {16'd0, avg[15:0]}, 32'd1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
